fpmul_arbiter: RTL and testbench
================================

# fpmul_arbiter

Round-robin arbiter and sequencer that shares one `multiplier32FP` instance between `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready channels, drives the multiplier's start/operand inputs, and waits for `done`. It then returns product, exception flags and requester ID on a single response channel with backpressure. It sits between the FP-consuming clients and the multiplier and is the only block allowed to drive the multiplier's inputs.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, default 64: watchdog limit in cycles. Used only when `FPMUL_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic rises on posedge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid_i` in N_REQ: request pending, one bit per requester.
- `req_ready_o` out N_REQ: grant; at most one bit high.
- `req_a_i` in 32·N_REQ: operand A; requester k uses bits [32k+31:32k].
- `req_b_i` in 32·N_REQ: operand B, packed the same way.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: response consumer ready.
- `rsp_id_o` out $clog2(N_REQ): index of the served requester.
- `rsp_product_o` out 32: IEEE-754 single-precision product.
- `rsp_flags_o` out 4: {nan, infinit, overflow, underflow}.
- `rsp_timeout_o` out 1: watchdog abort indicator; tied 0 when the macro is absent.
- `mul_start_o` out 1: multiplier start.
- `mul_a_o` out 32: multiplier operand A.
- `mul_b_o` out 32: multiplier operand B.
- `mul_product_i` in 32: multiplier result.
- `mul_done_i` in 1: multiplier done.
- `mul_nan_i`, `mul_infinit_i`, `mul_overflow_i`, `mul_underflow_i` in 1 each: multiplier exception flags.
- `busy_o` out 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP, DRAIN.
- **IDLE**
  - `req_ready_o` is the one-hot round-robin pick among `req_valid_i`. It is combinational and gated by `!mul_done_i`.
  - On acceptance (valid & ready): latch the operands into `mul_a_o`/`mul_b_o` and the ID into `rsp_id_o`; go to ISSUE.
  - The priority pointer moves to (granted+1) mod N_REQ. With no request pending, the pointer holds.
- **ISSUE**: `mul_start_o`=1 for exactly one cycle; go to WAIT_DONE. Operands stay stable until the next acceptance.
- **WAIT_DONE**: on `mul_done_i`=1, capture product and the four flags; go to RESP.
- **RESP**
  - `rsp_valid_o`=1; all response fields are stable while valid and not ready.
  - On `rsp_ready_i`, go to DRAIN if `mul_done_i` is still high, else to IDLE.
- **DRAIN**: wait for `mul_done_i`=0, then go to IDLE. This makes the block tolerant of a level-held done.
- One transaction is in flight at a time. No requester can be starved: the worst-case wait is N_REQ−1 transactions.
- A request that drops `req_valid_i` before its grant is simply not served.
- A `mul_done_i` seen in IDLE or ISSUE is ignored.

## Timing
- Acceptance at cycle t → `mul_start_o` at t+1.
- Done sampled at t+1+L → `rsp_valid_o` at t+2+L.
- Minimum gap between two grants: 4 cycles (L=1, `rsp_ready_i` held high, done low on the response cycle).
- Reset values:
  - state = IDLE, pointer = 0.
  - All outputs 0, including `req_ready_o`, `mul_start_o`, `mul_a_o`, `mul_b_o`, `rsp_*` and `busy_o`.
- Reset asserted mid-operation aborts the transaction immediately. No response is produced, and any later multiplier done is discarded.

## Configuration
- `FPMUL_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE. After `TIMEOUT_CYCLES` cycles without `mul_done_i`, go to RESP.
  - The response carries product 0x7FC00000, flags 4'b1000 and `rsp_timeout_o`=1.
  - Exit from RESP follows the normal rules (DRAIN if done is high).
- Undefined: no counter is built, WAIT_DONE waits indefinitely, and `rsp_timeout_o` is constant 0.

## Structure
- Package `fpmul_arb_pkg`:
  - state enum `fpmul_arb_state_t`.
  - packed struct `fp_flags_t` {nan, infinit, overflow, underflow}.
  - constant `FP_QNAN` = 32'h7FC00000.
- Sub-module `rr_arbiter`: parameterised N, pointer register, one-hot grant with an advance enable.

## Test plan
- Single request, requester 0: A=0x40000000, B=0x40400000 → `rsp_product_o`=0x40C00000, flags 0, id 0; `mul_start_o` is a single pulse.
- All four requesters valid continuously, pointer at 0 → grant order 0,1,2,3,0; each `rsp_id_o` matches its operands.
- `rsp_ready_i` held low 10 cycles → response fields stable, no new grant; on release → next grant proceeds.
- A=0x7F800000, B=0x00000000 → nan flag set, `rsp_flags_o`=4'b1000.
- With the macro defined, `mul_done_i` tied 0, TIMEOUT_CYCLES=64 → response at start+64 with 0x7FC00000 and `rsp_timeout_o`=1.
- `rst_n` pulsed during WAIT_DONE → all outputs 0 immediately; a following done pulse produces no response.

Source files
------------

// File: rtl/fpmul_arb_pkg.sv
// Shared types for the multiplier arbiter.
// Timeout watchdog is enabled by defining FPMUL_ARB_TIMEOUT_EN.
package fpmul_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } fpmul_arb_state_t;

    typedef struct packed {
        logic nan;
        logic infinit;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fpmul_arbiter_rr.sv
// Round-robin one-hot picker with a priority pointer.
// The pointer moves past the winner only when adv_i is set.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic                 adv_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && j >= int'(ptr_q)) begin
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IW'(j);
                found     = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j]) begin
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IW'(j);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            if (gnt_idx_o == IW'(N - 1)) ptr_d = '0;
            else ptr_d = gnt_idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one FP multiplier between N_REQ requesters.
// Define FPMUL_ARB_TIMEOUT_EN to build the WAIT_DONE watchdog.
module fpmul_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [32*N_REQ-1:0]      req_a_i,
    input  logic [32*N_REQ-1:0]      req_b_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic [31:0]              rsp_product_o,
    output logic [3:0]               rsp_flags_o,
    output logic                     rsp_timeout_o,
    output logic                     mul_start_o,
    output logic [31:0]              mul_a_o,
    output logic [31:0]              mul_b_o,
    input  logic [31:0]              mul_product_i,
    input  logic                     mul_done_i,
    input  logic                     mul_nan_i,
    input  logic                     mul_infinit_i,
    input  logic                     mul_overflow_i,
    input  logic                     mul_underflow_i,
    output logic                     busy_o
);
    localparam int IDW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("fpmul_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
    end

    fpmul_arb_state_t state_q, state_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [31:0]      prod_q, prod_d;
    logic [IDW-1:0]   id_q, id_d;
    fp_flags_t        flags_q, flags_d;

    logic             arb_en;
    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             accept;
    logic [31:0]      sel_a, sel_b;
    logic             to_hit;

    // A done still high from the last job must not open a new grant.
    assign arb_en  = (state_q == ST_IDLE) && !mul_done_i && rst_n;
    assign arb_req = req_valid_i & {N_REQ{arb_en}};
    assign accept  = |gnt;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (arb_req),
        .adv_i     (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sel_a = sel_a | ({32{gnt[k]}} & req_a_i[32*k +: 32]);
            sel_b = sel_b | ({32{gnt[k]}} & req_b_i[32*k +: 32]);
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        prod_d  = prod_q;
        flags_d = flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = gnt_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mul_done_i) begin
                    prod_d  = mul_product_i;
                    flags_d = '{nan:       mul_nan_i,
                                infinit:   mul_infinit_i,
                                overflow:  mul_overflow_i,
                                underflow: mul_underflow_i};
                    state_d = ST_RESP;
                end else if (to_hit) begin
                    prod_d  = FP_QNAN;
                    flags_d = fp_flags_t'(4'b1000);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) state_d = mul_done_i ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (!mul_done_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            prod_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            prod_q  <= prod_d;
            flags_q <= flags_d;
        end
    end

`ifdef FPMUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tout_q, tout_d;

    // The ISSUE cycle counts as the first cycle without done.
    assign to_hit = (state_q == ST_WAIT) &&
                    (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d  = cnt_q;
        tout_d = tout_q;
        if (state_q == ST_ISSUE) cnt_d = CW'(1);
        else if (state_q == ST_WAIT && !to_hit) cnt_d = cnt_q + CW'(1);
        if (accept) tout_d = 1'b0;
        else if (state_q == ST_WAIT && !mul_done_i && to_hit) tout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end

    assign rsp_timeout_o = tout_q;
`else
    assign to_hit        = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    assign req_ready_o   = gnt;
    assign mul_start_o   = (state_q == ST_ISSUE);
    assign mul_a_o       = a_q;
    assign mul_b_o       = b_q;
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_id_o      = id_q;
    assign rsp_product_o = prod_q;
    assign rsp_flags_o   = flags_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Scoreboard bench for fpmul_arbiter with a behavioural multiplier stub.
// Timeout scenario runs only when FPMUL_ARB_TIMEOUT_EN is defined.
module tb_fpmul_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [3:0]  f;
        logic        to;
    } op_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] p;
        logic [3:0]  f;
        logic        to;
    } exp_t;

    logic           clk, rst_n;
    logic [N-1:0]   req_valid, req_ready_o;
    logic [32*N-1:0] req_a, req_b;
    logic           rsp_valid_o, rsp_rdy, rsp_timeout_o;
    logic [1:0]     rsp_id_o;
    logic [31:0]    rsp_product_o;
    logic [3:0]     rsp_flags_o;
    logic           mul_start_o, busy_o;
    logic [31:0]    mul_a_o, mul_b_o, mul_prod;
    logic           mul_done, mul_nan, mul_inf, mul_ovf, mul_unf;

    op_t  rq[N][$];
    exp_t sb[$];
    int   grants[$];
    int   acc_log[$];
    int   cyc, acc_cyc, start_cyc, rsp_cyc, rsp_count, gate_err;
    int   lat, hold, kick_req;
    bit   silent;
    int   n_chk, n_pass;

    fpmul_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_a_i         (req_a),
        .req_b_i         (req_b),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_rdy),
        .rsp_id_o        (rsp_id_o),
        .rsp_product_o   (rsp_product_o),
        .rsp_flags_o     (rsp_flags_o),
        .rsp_timeout_o   (rsp_timeout_o),
        .mul_start_o     (mul_start_o),
        .mul_a_o         (mul_a_o),
        .mul_b_o         (mul_b_o),
        .mul_product_i   (mul_prod),
        .mul_done_i      (mul_done),
        .mul_nan_i       (mul_nan),
        .mul_infinit_i   (mul_inf),
        .mul_overflow_i  (mul_ovf),
        .mul_underflow_i (mul_unf),
        .busy_o          (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [3:0] f, input logic to);
        op_t o;
        o.a = a; o.b = b; o.p = p; o.f = f; o.to = to;
        rq[k].push_back(o);
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++)
            if (rq[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference products for the directed operand pairs: {flags, product}.
    function automatic logic [35:0] lut(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return {4'b0000, 32'h40C00000};
            {32'h3F800000, 32'h3F800000}: return {4'b0000, 32'h3F800000};
            {32'h40800000, 32'h3F000000}: return {4'b0000, 32'h40000000};
            {32'hBF800000, 32'h40A00000}: return {4'b0000, 32'hC0A00000};
            {32'h40400000, 32'h40400000}: return {4'b0000, 32'h41100000};
            {32'h7F800000, 32'h00000000}: return {4'b1000, 32'h7FC00000};
            {32'h7F800000, 32'h40000000}: return {4'b0100, 32'h7F800000};
            {32'h7F000000, 32'h7F000000}: return {4'b0010, 32'h7F800000};
            {32'h00800000, 32'h00800000}: return {4'b0001, 32'h00000000};
            default:                      return {4'b0000, 32'hDEADBEEF};
        endcase
    endfunction

    // Requester driver: head of each queue is presented until accepted.
    initial begin
        exp_t e;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (rq[k].size() != 0) begin
                    req_valid[k]       = 1'b1;
                    req_a[32*k +: 32]  = rq[k][0].a;
                    req_b[32*k +: 32]  = rq[k][0].b;
                end else begin
                    req_valid[k] = 1'b0;
                end
            end
            #4;
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && req_ready_o[k]) begin
                    e.id = 2'(k);
                    e.p  = rq[k][0].p;
                    e.f  = rq[k][0].f;
                    e.to = rq[k][0].to;
                    sb.push_back(e);
                    grants.push_back(k);
                    acc_cyc = cyc;
                    acc_log.push_back(cyc);
                    void'(rq[k].pop_front());
                end
            end
        end
    end

    // Multiplier stub: done after lat cycles, held for hold cycles.
    initial begin
        int kick_seen;
        logic [35:0] r;
        kick_seen = 0;
        mul_done = 1'b0;
        mul_prod = '0;
        {mul_nan, mul_inf, mul_ovf, mul_unf} = 4'b0;
        forever begin
            @(negedge clk);
            if (kick_req != kick_seen) begin
                kick_seen = kick_req;
                mul_prod  = 32'h12345678;
                mul_done  = 1'b1;
                @(negedge clk);
                mul_done  = 1'b0;
            end else if (mul_start_o) begin
                start_cyc = cyc;
                if (!silent) begin
                    r = lut(mul_a_o, mul_b_o);
                    repeat (lat) @(negedge clk);
                    mul_prod = r[31:0];
                    {mul_nan, mul_inf, mul_ovf, mul_unf} = r[35:32];
                    mul_done = 1'b1;
                    repeat (hold) @(negedge clk);
                    mul_done = 1'b0;
                    {mul_nan, mul_inf, mul_ovf, mul_unf} = 4'b0;
                end
            end
        end
    end

    // Monitor: start pulse width, done gating, response scoreboard.
    initial begin
        int run;
        bit pv;
        exp_t e;
        run = 0;
        pv  = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (mul_start_o) run++;
            else if (run > 0) begin
                chk("start_width", run, 1);
                run = 0;
            end
            if (mul_done && |req_ready_o) gate_err++;
            if (rsp_valid_o && !pv) rsp_cyc = cyc;
            pv = rsp_valid_o;
            if (rsp_valid_o && rsp_rdy) begin
                rsp_count++;
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL rsp_unexpected: got id %0d product %h, expected no response",
                             rsp_id_o, rsp_product_o);
                end else begin
                    e = sb.pop_front();
                    chk("rsp", {rsp_id_o, rsp_product_o, rsp_flags_o, rsp_timeout_o}, e);
                end
            end
        end
    end

    task automatic wait_quiet(input string nm, input int budget);
        int n;
        n = 0;
        while ((pending() || sb.size() != 0 || busy_o) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, n < budget, 1);
    endtask

    function automatic logic [127:0] all_out();
        return {req_ready_o, rsp_valid_o, rsp_id_o, rsp_product_o, rsp_flags_o,
                rsp_timeout_o, mul_start_o, mul_a_o, mul_b_o, busy_o};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: still running, %0d/%0d checks so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int order[5];
        int n, stall_err, base;
        logic [38:0] snap;
        order = '{0, 1, 2, 3, 0};
        n_chk = 0; n_pass = 0; rsp_count = 0; gate_err = 0;
        lat = 1; hold = 1; silent = 1'b0; kick_req = 0;
        rsp_rdy = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out(), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push(0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 1'b0);
        wait_quiet("single_done", 50);
        chk("start_latency", start_cyc - acc_cyc, 1);
        chk("rsp_latency", rsp_cyc - acc_cyc, 2 + lat);

        push(3, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1'b0);
        wait_quiet("nan_done", 50);

        grants.delete();
        acc_log.delete();
        push(0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 1'b0);
        push(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 1'b0);
        push(2, 32'h40800000, 32'h3F000000, 32'h40000000, 4'b0000, 1'b0);
        push(3, 32'hBF800000, 32'h40A00000, 32'hC0A00000, 4'b0000, 1'b0);
        push(0, 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 1'b0);
        wait_quiet("rr_done", 100);
        chk("grant_count", grants.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("grant_order_%0d", i),
                (i < grants.size()) ? grants[i] : -1, order[i]);
        chk("grant_gap", (acc_log.size() > 1) ? acc_log[1] - acc_log[0] : -1, 4);

        rsp_rdy = 1'b0;
        grants.delete();
        push(1, 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 1'b0);
        push(2, 32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0100, 1'b0);
        n = 0;
        while (!rsp_valid_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_rsp_seen", n < 50, 1);
        snap = {rsp_id_o, rsp_product_o, rsp_flags_o, rsp_timeout_o};
        stall_err = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if ({rsp_id_o, rsp_product_o, rsp_flags_o, rsp_timeout_o} !== snap ||
                |req_ready_o || mul_start_o || !rsp_valid_o)
                stall_err++;
        end
        chk("bp_stable", stall_err, 0);
        chk("bp_no_grant", grants.size(), 1);
        rsp_rdy = 1'b1;
        wait_quiet("bp_done", 50);
        chk("bp_next_grant", (grants.size() > 1) ? grants[1] : -1, 2);

        hold = 3;
        push(0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0010, 1'b0);
        push(3, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0001, 1'b0);
        wait_quiet("drain_done", 80);
        hold = 1;
        chk("done_gate", gate_err, 0);

`ifdef FPMUL_ARB_TIMEOUT_EN
        silent = 1'b1;
        push(1, 32'h40000000, 32'h40400000, 32'h7FC00000, 4'b1000, 1'b1);
        wait_quiet("timeout_done", 200);
        chk("timeout_latency", rsp_cyc - start_cyc, TO);
        silent = 1'b0;
`endif

        silent = 1'b1;
        push(2, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 1'b0);
        n = 0;
        while (!mul_start_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        chk("pre_reset_busy", busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop_reset_outputs", all_out(), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        silent = 1'b0;
        base = rsp_count;
        kick_req++;
        repeat (10) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", rsp_count, base);
        chk("idle_after_reset", busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
